decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the register file. Takes instruction words

---
 rtl/decode_issue_if.sv | 43 ++++
 rtl/decode_issue.sv | 124 ++++++++++++
 tb/tb_decode_issue.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Bus bundle between decode_issue and its neighbours. The neighbours are fetch,
// the register-file read ports, the execute issue slot and writeback.
// The slave modport is the decode stage. The master modport is the environment
// around it.
interface decode_issue_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int OPC_W      = 4,
  parameter int INSTR_W    = 16
);
  // fetch -> decode
  logic                  in_valid;
  logic [INSTR_W-1:0]    in_instr;
  logic                  in_ready;
  // register-file read ports
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  // issue slot -> execute
  logic                  out_valid;
  logic                  out_ready;
  logic [OPC_W-1:0]      out_opc;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wr;
  logic [DATA_W-1:0]     out_rs_val;
  logic [DATA_W-1:0]     out_rt_val;
  // writeback retire
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;

  modport slave (
    input  in_valid, in_instr, rs_data, rt_data, out_ready, wb_valid, wb_rd,
    output in_ready, rs_addr, rt_addr, out_valid, out_opc, out_rd, out_wr,
           out_rs_val, out_rt_val
  );

  modport master (
    output in_valid, in_instr, rs_data, rt_data, out_ready, wb_valid, wb_rd,
    input  in_ready, rs_addr, rt_addr, out_valid, out_opc, out_rd, out_wr,
           out_rs_val, out_rt_val
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage. It decodes {opcode, rd, rs, rt} and drives the
// register-file read addresses. A per-register busy scoreboard blocks RAW and
// WAW hazards. Accepted ops are registered into a single valid/ready issue slot
// that feeds execute.
module decode_issue #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int OPC_W      = 4,
  parameter int INSTR_W    = 16,
  parameter int STALL_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,      // asynchronous, active low
  decode_issue_if.slave                bus,
  output logic [(1<<REG_ADDR_W)-1:0]   busy_o,
  output logic [STALL_W-1:0]           stall_cnt
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [OPC_W-1:0]   OPC_NOP   = '1;
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  // Decoded fields of the presented instruction.
  logic [OPC_W-1:0]      dec_opc;
  logic [REG_ADDR_W-1:0] dec_rd, dec_rs, dec_rt;
  logic                  dec_nop, dec_wr;

  // Stage state.
  logic [NREG-1:0]       busy_q, busy_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  valid_q, valid_d;
  logic [OPC_W-1:0]      opc_q, opc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_W-1:0]     rs_val_q, rs_val_d;
  logic [DATA_W-1:0]     rt_val_q, rt_val_d;

  logic hazard, slot_free, issue;

  assign dec_opc = bus.in_instr[INSTR_W-1 -: OPC_W];
  assign dec_rd  = bus.in_instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
  assign dec_rs  = bus.in_instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign dec_rt  = bus.in_instr[REG_ADDR_W-1:0];
  assign dec_nop = (dec_opc == OPC_NOP);
  // Lower half of the opcode space writes rd; upper half (except NOP) only reads.
  assign dec_wr  = !dec_nop && !dec_opc[OPC_W-1];

  // Register-file reads are straight off the instruction; data returns combinationally.
  assign bus.rs_addr = dec_rs;
  assign bus.rt_addr = dec_rt;

  // Hazard check uses the registered busy vector only. A retire in the same
  // cycle is not bypassed, so the stalled op issues one cycle later.
  assign hazard    = bus.in_valid && !dec_nop &&
                     (busy_q[dec_rs] || busy_q[dec_rt] || (dec_wr && busy_q[dec_rd]));
  assign slot_free = !valid_q || bus.out_ready;
  assign bus.in_ready = slot_free && !hazard;
  assign issue     = bus.in_valid && bus.in_ready;

  // Next-state for the scoreboard, stall counter and issue slot.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    busy_d   = busy_q;
    stall_d  = stall_q;
    valid_d  = valid_q;
    opc_d    = opc_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;

    // Clear before set: an issuing op is younger than the retiring write, so set wins.
    if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
    if (issue && dec_wr) busy_d[dec_rd] = 1'b1;

    if (hazard && (stall_q != '1)) stall_d = stall_q + STALL_ONE;

    if (issue) begin
      valid_d  = 1'b1;
      opc_d    = dec_opc;
      rd_d     = dec_rd;
      wr_d     = dec_wr;
      rs_val_d = bus.rs_data;
      rt_val_d = bus.rt_data;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the slot payload is reset as well, so execute never sees X fields after reset.
      busy_q   <= '0;
      stall_q  <= '0;
      valid_q  <= 1'b0;
      opc_q    <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      rs_val_q <= '0;
      rt_val_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      valid_q  <= valid_d;
      opc_q    <= opc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_opc    = opc_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_wr     = wr_q;
  assign bus.out_rs_val = rs_val_q;
  assign bus.out_rt_val = rt_val_q;
  assign busy_o         = busy_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue. A reference model tracks busy bits, stall count and
// slot occupancy, and predicts in_ready. A scoreboard queue holds expected slot
// contents from accept until execute consumes them.
module tb_decode_issue;
  localparam int STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  rd;
    logic        wr;
    logic [31:0] rs;
    logic [31:0] rt;
  } slot_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] busy_o;
  logic [STALL_W-1:0] stall_cnt;

  decode_issue_if #(.DATA_W(32), .REG_ADDR_W(4), .OPC_W(4), .INSTR_W(16)) bus ();

  decode_issue #(
    .DATA_W(32), .REG_ADDR_W(4), .OPC_W(4), .INSTR_W(16), .STALL_W(STALL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy_o   (busy_o),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model with a combinational read.
  logic [31:0] rf [16];
  assign bus.rs_data = rf[bus.rs_addr];
  assign bus.rt_data = rf[bus.rt_addr];

  // Reference model state.
  logic [15:0]        busy_m;
  logic [STALL_W-1:0] stall_m;
  logic               valid_m;
  slot_t              sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // One clock of the model plus checks. Inputs are already driven at this point.
  task automatic step();
    logic [3:0] opc, rd, rs, rt;
    logic nop, wr, hz, exp_ready, acc, cons;
    slot_t e, got;
    #1;
    {opc, rd, rs, rt} = bus.in_instr;
    nop = (opc == 4'hF);
    wr  = !nop && !opc[3];
    hz  = bus.in_valid && !nop && (busy_m[rs] || busy_m[rt] || (wr && busy_m[rd]));
    exp_ready = (!valid_m || bus.out_ready) && !hz;
    n_checks++;
    if (bus.in_ready !== exp_ready) begin
      n_fail++; $display("FAIL in_ready: got %b expected %b (instr %h)", bus.in_ready, exp_ready, bus.in_instr);
    end
    n_checks++;
    if (bus.out_valid !== valid_m) begin
      n_fail++; $display("FAIL out_valid: got %b expected %b", bus.out_valid, valid_m);
    end
    acc  = bus.in_valid && exp_ready;
    cons = valid_m && bus.out_ready;
    if (cons) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL scoreboard_underflow: slot consumed with nothing expected");
      end else begin
        e   = sb.pop_front();
        got = {bus.out_opc, bus.out_rd, bus.out_wr, bus.out_rs_val, bus.out_rt_val};
        if (got !== e) begin
          n_fail++; $display("FAIL slot_payload: got %h expected %h", got, e);
        end
      end
    end
    if (acc) begin
      e = {opc, rd, wr, rf[rs], rf[rt]};
      sb.push_back(e);
    end
    if (bus.wb_valid) busy_m[bus.wb_rd] = 1'b0;
    if (acc && wr) busy_m[rd] = 1'b1;
    if (hz && stall_m != STALL_MAX) stall_m = stall_m + 1'b1;
    valid_m = acc ? 1'b1 : (cons ? 1'b0 : valid_m);
    @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== busy_m) begin
      n_fail++; $display("FAIL busy: got %h expected %h", busy_o, busy_m);
    end
    n_checks++;
    if (stall_cnt !== stall_m) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall_m);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic ordy,
                       input logic wv, input logic [3:0] wrd);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_rd     = wrd;
  endtask

  task automatic model_reset();
    busy_m = '0; stall_m = '0; valid_m = 1'b0; sb.delete();
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (busy_o !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0000", busy_o); end
    n_checks++;
    if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    n_checks++;
    if ({bus.out_opc, bus.out_rd, bus.out_wr, bus.out_rs_val, bus.out_rt_val} !== '0) begin
      n_fail++; $display("FAIL reset_slot: slot fields nonzero after reset (opc %h rd %h)", bus.out_opc, bus.out_rd);
    end
    step();
  endtask

  task automatic test_issue();
    drive(1'b1, 16'h1234, 1'b1, 1'b0, 4'h0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 4'h2 || bus.out_wr !== 1'b1) begin
      n_fail++; $display("FAIL issue_fields: valid %b rd %h wr %b expected 1 2 1", bus.out_valid, bus.out_rd, bus.out_wr);
    end
    n_checks++;
    if (busy_o !== 16'h0004) begin n_fail++; $display("FAIL issue_busy: got %h expected 0004", busy_o); end
    n_checks++;
    if (bus.out_rs_val !== 32'hA000_0333) begin n_fail++; $display("FAIL issue_rs_val: got %h expected a0000333", bus.out_rs_val); end
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h2);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_raw_stall();
    logic [STALL_W-1:0] s0;
    drive(1'b1, 16'h1234, 1'b1, 1'b0, 4'h0);
    step();
    s0 = stall_cnt;
    drive(1'b1, 16'h3521, 1'b1, 1'b0, 4'h0);
    repeat (3) step();
    n_checks++;
    if (stall_cnt !== s0 + 3'd3) begin n_fail++; $display("FAIL raw_stall_count: got %0d expected %0d", stall_cnt, s0 + 3'd3); end
    // Retire r2 at cycle T: still stalled this cycle.
    drive(1'b1, 16'h3521, 1'b1, 1'b1, 4'h2);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_no_bypass: in_ready got %b expected 0", bus.in_ready); end
    step();
    drive(1'b1, 16'h3521, 1'b1, 1'b0, 4'h0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue_t1: in_ready got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_opc !== 4'h3 || bus.out_rd !== 4'h5) begin
      n_fail++; $display("FAIL raw_issued: valid %b opc %h rd %h expected 1 3 5", bus.out_valid, bus.out_opc, bus.out_rd);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h5);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_backpressure();
    slot_t snap;
    logic [STALL_W-1:0] s0;
    drive(1'b1, 16'h2600, 1'b0, 1'b0, 4'h0);
    step();
    drive(1'b1, 16'h8111, 1'b0, 1'b0, 4'h0);
    snap = {bus.out_opc, bus.out_rd, bus.out_wr, bus.out_rs_val, bus.out_rt_val};
    s0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      step();
      n_checks++;
      if ({bus.out_opc, bus.out_rd, bus.out_wr, bus.out_rs_val, bus.out_rt_val} !== snap || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: slot changed while stalled (opc %h rd %h)", i, bus.out_opc, bus.out_rd);
      end
      n_checks++;
      if (stall_cnt !== s0) begin n_fail++; $display("FAIL bp_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, s0); end
    end
    drive(1'b1, 16'h8111, 1'b1, 1'b0, 4'h0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_opc !== 4'h8 || bus.out_wr !== 1'b0) begin
      n_fail++; $display("FAIL bp_back_to_back: valid %b opc %h wr %b expected 1 8 0", bus.out_valid, bus.out_opc, bus.out_wr);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: out_valid got %b expected 0", bus.out_valid); end
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h6);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_waw_wb();
    drive(1'b1, 16'h0500, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    // Same-cycle retire of r5 does not unblock the WAW hazard.
    drive(1'b1, 16'h0500, 1'b1, 1'b1, 4'h5);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_hazard: in_ready got %b expected 0", bus.in_ready); end
    step();
    n_checks++;
    if (busy_o[5] !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL waw_no_issue: busy5 %b out_valid %b expected 0 0", busy_o[5], bus.out_valid);
    end
    drive(1'b1, 16'h0500, 1'b1, 1'b0, 4'h0);
    step();
    n_checks++;
    if (busy_o[5] !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL waw_issue: busy5 %b out_valid %b expected 1 1", busy_o[5], bus.out_valid);
    end
    // Set and clear of r9 in one cycle: set wins.
    drive(1'b1, 16'h0900, 1'b1, 1'b1, 4'h9);
    step();
    n_checks++;
    if (busy_o !== 16'h0220) begin n_fail++; $display("FAIL set_wins: busy got %h expected 0220", busy_o); end
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h5);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h9);
    step();
    // Retire of a register that is not busy changes nothing.
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'hC);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_stall_saturate();
    drive(1'b1, 16'h0700, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 16'h8077, 1'b1, 1'b0, 4'h0);
    repeat ((1 << STALL_W) + 3) step();
    n_checks++;
    if (stall_cnt !== STALL_MAX) begin n_fail++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, STALL_MAX); end
    drive(1'b1, 16'h8077, 1'b1, 1'b1, 4'h7);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    step();
    n_checks++;
    if (stall_cnt !== STALL_MAX) begin n_fail++; $display("FAIL stall_no_wrap: got %0d expected %0d", stall_cnt, STALL_MAX); end
  endtask

  task automatic test_nop_stream();
    drive(1'b1, 16'hF000, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_opc !== 4'hF || bus.out_wr !== 1'b0 || busy_o !== 16'h0) begin
        n_fail++; $display("FAIL nop_issue[%0d]: valid %b opc %h wr %b busy %h", i, bus.out_valid, bus.out_opc, bus.out_wr, busy_o);
      end
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    repeat (2) step();
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 16'h0100, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 16'h0400, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0);
    n_checks++;
    if (busy_o !== 16'h0012 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: busy %h valid %b expected 0012 1", busy_o, bus.out_valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy_o !== 16'h0 || stall_cnt !== '0) begin
      n_fail++; $display("FAIL async_reset: valid %b busy %h stall %0d expected 0 0000 0", bus.out_valid, busy_o, stall_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + 32'h111 * i;
    test_reset();
    test_issue();
    test_raw_stall();
    test_backpressure();
    test_waw_wb();
    test_stall_saturate();
    test_nop_stream();
    test_reset_midstream();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d expected ops never consumed", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
